// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, D-stage output register,
// branch redirect with drop of stale responses. Optional macro FETCH_MISALIGN_TRAP_EN.
module fetch_ctrl #(
    parameter int              DPW          = 32,
    parameter logic [DPW-1:0]  RESET_VECTOR = 32'h0000_0000,
    parameter logic [DPW-1:0]  TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            stall_i,
    input  logic            branchE,
    input  logic            zero_flag,
    input  logic [DPW-1:0]  PCE,
    input  logic [DPW-1:0]  immextE,
    output logic            imem_req_o,
    output logic [DPW-1:0]  imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic [31:0]     instrD_o,
    output logic [DPW-1:0]  PCD_o,
    output logic            validD_o,
    output logic            flushD_o
);

    typedef enum logic [1:0] {ST_BOOT, ST_REQ, ST_WAIT, ST_HOLD} state_t;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t          state;
    logic [DPW-1:0]  pc;
    logic            drop;
    logic            taken;
    logic [DPW-1:0]  target_raw;
    logic [DPW-1:0]  target;
    logic [DPW-1:0]  pc_inc;

    assign taken      = branchE & zero_flag;
    assign target_raw = PCE + immextE;
    assign pc_inc     = pc + DPW'(4);
    // An aligned raw target equals its forced-aligned form, so one mux covers both builds.
    assign target     = (TRAP_EN && (target_raw[1:0] != 2'b00)) ? TRAP_VECTOR
                                                                 : {target_raw[DPW-1:2], 2'b00};

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values;
    // later assignments in the block (redirect) deliberately override the defaults above them.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= ST_BOOT;
            pc          <= RESET_VECTOR;
            drop        <= 1'b0;
            imem_req_o  <= 1'b0;
            imem_addr_o <= RESET_VECTOR;
            instrD_o    <= 32'h0000_0013;
            PCD_o       <= '0;
            validD_o    <= 1'b0;
            flushD_o    <= 1'b0;
        end else begin
            flushD_o <= 1'b0;
            validD_o <= validD_o & stall_i;
            case (state)
                ST_BOOT: begin
                    state       <= ST_REQ;
                    pc          <= RESET_VECTOR;
                    imem_req_o  <= 1'b1;
                    imem_addr_o <= RESET_VECTOR;
                end
                ST_REQ: begin
                    if (taken) begin
                        pc       <= target;
                        flushD_o <= 1'b1;
                        validD_o <= 1'b0;
                        if (imem_gnt_i) begin
                            state      <= ST_WAIT;
                            imem_req_o <= 1'b0;
                            drop       <= 1'b1;
                        end else begin
                            imem_addr_o <= target;
                        end
                    end else if (imem_gnt_i) begin
                        state      <= ST_WAIT;
                        imem_req_o <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (taken) begin
                        pc       <= target;
                        flushD_o <= 1'b1;
                        validD_o <= 1'b0;
                        if (imem_rvalid_i) begin
                            state       <= ST_REQ;
                            imem_req_o  <= 1'b1;
                            imem_addr_o <= target;
                            drop        <= 1'b0;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (imem_rvalid_i) begin
                        if (drop) begin
                            drop        <= 1'b0;
                            state       <= ST_REQ;
                            imem_req_o  <= 1'b1;
                            imem_addr_o <= pc;
                        end else begin
                            instrD_o    <= imem_rdata_i;
                            PCD_o       <= pc;
                            validD_o    <= 1'b1;
                            pc          <= pc_inc;
                            imem_addr_o <= pc_inc;
                            if (stall_i) begin
                                state <= ST_HOLD;
                            end else begin
                                state      <= ST_REQ;
                                imem_req_o <= 1'b1;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (taken) begin
                        pc          <= target;
                        flushD_o    <= 1'b1;
                        validD_o    <= 1'b0;
                        state       <= ST_REQ;
                        imem_req_o  <= 1'b1;
                        imem_addr_o <= target;
                    end else if (!stall_i) begin
                        state       <= ST_REQ;
                        imem_req_o  <= 1'b1;
                        imem_addr_o <= pc;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule
